stamp_counter_sched: RTL and testbench

- Controller and scheduler around the free-running timestamp counter.
- Owns the counter register. Advances it by a programmable fixed-point increment each cycle.
- Accepts one load/adjust/set-increment command at a time through a valid/ready handshake.
- Shares snapshot access to the counter between NUM_REQ requesters (e.g. per-port RX/TX stampers) using round-robin arbitration.

---
 rtl/stamp_pkg.sv | 12 +
 rtl/stamp_counter_sched_if.sv | 27 ++
 rtl/stamp_rr_arbiter.sv | 44 ++++
 rtl/stamp_counter_sched.sv | 101 ++++++++++
 tb/tb_stamp_counter_sched.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/stamp_pkg.sv
// stamp_pkg: command encodings, FSM state type and default increments for the stamp counter scheduler.
package stamp_pkg;
  typedef enum logic [1:0] {
    CMD_SET_INC_INT  = 2'b00,
    CMD_LOAD         = 2'b01,
    CMD_ADJUST       = 2'b10,
    CMD_SET_INC_FRAC = 2'b11
  } cmd_op_e;
  typedef enum logic {ST_IDLE, ST_EXEC} state_e;
  localparam logic [7:0] DEF_INC_INT  = 8'd1;
  localparam int         DEF_INC_FRAC = 0;
endpackage

// File: rtl/stamp_counter_sched_if.sv
// stamp_counter_sched_if: command handshake, snapshot request/grant and live stamp bundle.
interface stamp_counter_sched_if
  import stamp_pkg::*;
#(
  parameter int TIMESTAMP_WIDTH = 64,
  parameter int NUM_REQ         = 4,
  parameter int ID_WIDTH        = 2
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  cmd_op_e                    cmd_op;
  logic [TIMESTAMP_WIDTH-1:0] cmd_data;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ-1:0]         gnt;
  logic                       snap_valid;
  logic [TIMESTAMP_WIDTH-1:0] snap_data;
  logic [ID_WIDTH-1:0]        snap_id;
  logic [TIMESTAMP_WIDTH-1:0] stamp_counter;
  modport master (
    output cmd_valid, cmd_op, cmd_data, req,
    input  cmd_ready, gnt, snap_valid, snap_data, snap_id, stamp_counter
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, req,
    output cmd_ready, gnt, snap_valid, snap_data, snap_id, stamp_counter
  );
endinterface

// File: rtl/stamp_rr_arbiter.sv
// stamp_rr_arbiter: round-robin arbiter with registered one-hot grant, valid and granted index.
module stamp_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  i_req,
  output logic [NUM_REQ-1:0]  o_gnt,
  output logic                o_valid,
  output logic [ID_WIDTH-1:0] o_idx
);
  logic [ID_WIDTH-1:0] r_ptr;
  logic [ID_WIDTH-1:0] w_pick;
  logic [ID_WIDTH-1:0] w_ptr_nxt;
  logic [NUM_REQ-1:0]  w_rot;
  logic                w_hit;
  // rotate so bit 0 is the pointer position; scanning downwards leaves the nearest request
  always_comb begin
    w_rot  = NUM_REQ'({i_req, i_req} >> r_ptr);
    w_hit  = 1'b0;
    w_pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (w_rot[i]) begin
        w_hit  = 1'b1;
        w_pick = ID_WIDTH'((int'(r_ptr) + i) % NUM_REQ);
      end
    w_ptr_nxt = (w_pick == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_pick + 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ptr   <= '0;
      o_gnt   <= '0;
      o_valid <= 1'b0;
      o_idx   <= '0;
    end else begin
      o_valid <= w_hit;
      o_gnt   <= w_hit ? NUM_REQ'(1) << w_pick : '0;
      if (w_hit) begin
        o_idx <= w_pick;
        r_ptr <= w_ptr_nxt;
      end
    end
endmodule

// File: rtl/stamp_counter_sched.sv
// stamp_counter_sched: fixed-point timestamp accumulator with command FSM and round-robin snapshot access.
// Optional PPS capture enabled by STAMP_COUNTER_SCHED_PPS_EN.
module stamp_counter_sched
  import stamp_pkg::*;
#(
  parameter int TIMESTAMP_WIDTH = 64,
  parameter int FRAC_WIDTH      = 24,
  parameter int NUM_REQ         = 4,
  parameter int ID_WIDTH        = 2
) (
  input  logic                       axi_aclk,
  input  logic                       axi_reset,
  stamp_counter_sched_if.slave       bus
`ifdef STAMP_COUNTER_SCHED_PPS_EN
  ,
  input  logic                       pps,
  output logic                       pps_valid,
  output logic [TIMESTAMP_WIDTH-1:0] pps_stamp
`endif
);
  localparam int AW = TIMESTAMP_WIDTH + FRAC_WIDTH;
  logic [AW-1:0]              r_acc;
  state_e                     r_state;
  logic                       r_cmd_ready;
  cmd_op_e                    r_op;
  logic [TIMESTAMP_WIDTH-1:0] r_data;
  logic [7:0]                 r_inc_int;
  logic [FRAC_WIDTH-1:0]      r_inc_frac;
  logic [TIMESTAMP_WIDTH-1:0] r_snap_data;
  logic [AW-1:0]              w_inc;
  logic [AW-1:0]              w_adj;
  logic [AW-1:0]              w_acc_nxt;
  logic [TIMESTAMP_WIDTH-1:0] w_stamp;
  logic                       w_exec;
  logic                       w_fire;
  assign w_stamp = r_acc[AW-1:FRAC_WIDTH];
  assign w_exec  = r_state == ST_EXEC;
  assign w_fire  = bus.cmd_valid & r_cmd_ready;
  assign w_inc   = AW'({r_inc_int, r_inc_frac});
  // adjust rides on top of the normal increment; operand is full stamp width so sign extension is implicit
  assign w_adj     = (w_exec && r_op == CMD_ADJUST) ? {r_data, {FRAC_WIDTH{1'b0}}} : '0;
  assign w_acc_nxt = (w_exec && r_op == CMD_LOAD) ? {r_data, {FRAC_WIDTH{1'b0}}} : r_acc + w_inc + w_adj;
  always_ff @(posedge axi_aclk or posedge axi_reset)
    if (axi_reset) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_op        <= CMD_SET_INC_INT;
      r_data      <= '0;
      r_inc_int   <= DEF_INC_INT;
      r_inc_frac  <= FRAC_WIDTH'(DEF_INC_FRAC);
    end else if (r_state == ST_IDLE) begin
      r_cmd_ready <= !w_fire;
      if (w_fire) begin
        r_state <= ST_EXEC;
        r_op    <= bus.cmd_op;
        r_data  <= bus.cmd_data;
      end
    end else begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b1;
      if (r_op == CMD_SET_INC_INT) r_inc_int <= r_data[7:0];
      if (r_op == CMD_SET_INC_FRAC) r_inc_frac <= r_data[FRAC_WIDTH-1:0];
    end
  // snapshot samples the pre-increment stamp on the same edge the arbiter registers its grant
  always_ff @(posedge axi_aclk or posedge axi_reset)
    if (axi_reset) begin
      r_acc       <= '0;
      r_snap_data <= '0;
    end else begin
      r_acc <= w_acc_nxt;
      if (|bus.req) r_snap_data <= w_stamp;
    end
  stamp_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_arb (
    .clk     (axi_aclk),
    .rst     (axi_reset),
    .i_req   (bus.req),
    .o_gnt   (bus.gnt),
    .o_valid (bus.snap_valid),
    .o_idx   (bus.snap_id)
  );
  assign bus.cmd_ready     = r_cmd_ready;
  assign bus.snap_data     = r_snap_data;
  assign bus.stamp_counter = w_stamp;
`ifdef STAMP_COUNTER_SCHED_PPS_EN
  logic [2:0]                 r_pps_sync;
  logic                       r_pps_valid;
  logic [TIMESTAMP_WIDTH-1:0] r_pps_stamp;
  always_ff @(posedge axi_aclk or posedge axi_reset)
    if (axi_reset) begin
      r_pps_sync  <= '0;
      r_pps_valid <= 1'b0;
      r_pps_stamp <= '0;
    end else begin
      r_pps_sync  <= {r_pps_sync[1:0], pps};
      r_pps_valid <= r_pps_sync[1] & ~r_pps_sync[2];
      if (r_pps_sync[1] & ~r_pps_sync[2]) r_pps_stamp <= w_stamp;
    end
  assign pps_valid = r_pps_valid;
  assign pps_stamp = r_pps_stamp;
`endif
endmodule

// File: tb/tb_stamp_counter_sched.sv
// tb_stamp_counter_sched: table-driven command vectors plus snapshot scoreboard for stamp_counter_sched.
module tb_stamp_counter_sched;
  import stamp_pkg::*;
  localparam int TW = 64;
  localparam int FW = 24;
  localparam int NR = 4;
  localparam int IW = 2;
  typedef struct {
    cmd_op_e       op;
    logic [TW-1:0] data;
    int            n;
    logic [TW-1:0] exp;
  } vec_t;
  typedef struct {
    logic [IW-1:0] id;
    logic [TW-1:0] data;
  } snap_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  stamp_counter_sched_if #(.TIMESTAMP_WIDTH(TW), .NUM_REQ(NR), .ID_WIDTH(IW)) bus ();
`ifdef STAMP_COUNTER_SCHED_PPS_EN
  logic          pps = 1'b0;
  logic          pps_valid;
  logic [TW-1:0] pps_stamp;
`endif
  stamp_counter_sched #(.TIMESTAMP_WIDTH(TW), .FRAC_WIDTH(FW), .NUM_REQ(NR), .ID_WIDTH(IW)) dut (
    .axi_aclk  (clk),
    .axi_reset (rst),
    .bus       (bus.slave)
`ifdef STAMP_COUNTER_SCHED_PPS_EN
    ,
    .pps       (pps),
    .pps_valid (pps_valid),
    .pps_stamp (pps_stamp)
`endif
  );
  int      n_vec = 0;
  int      n_bad = 0;
  int      m_ptr = 0;
  snap_t   sq[$];
  vec_t    tbl[13];
  logic [TW-1:0] st;
  task automatic chk(string nm, logic [TW-1:0] act, logic [TW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic int rr_pick(logic [NR-1:0] r);
    for (int i = 0; i < NR; i++) begin
      int k = (m_ptr + i) % NR;
      if (((r >> k) & NR'(1)) != 0) begin
        m_ptr = (k + 1) % NR;
        return k;
      end
    end
    return 0;
  endfunction
  task automatic cmd(cmd_op_e op, logic [TW-1:0] d);
    int w = 0;
    while (!bus.cmd_ready && w < 10) begin
      tick();
      w++;
    end
    chk("cmd_ready_idle", 64'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    tick();
    bus.cmd_valid = 1'b0;
    chk("cmd_ready_exec", 64'(bus.cmd_ready), 0);
    tick();
    chk("cmd_ready_back", 64'(bus.cmd_ready), 1);
  endtask
  task automatic run_req(logic [NR-1:0] r, int cycles);
    bus.req = r;
    for (int k = 0; k < cycles; k++) begin
      snap_t e;
      e.id   = IW'(rr_pick(r));
      e.data = st;
      sq.push_back(e);
      st++;
      tick();
    end
    bus.req = '0;
  endtask
  always @(negedge clk)
    if (!rst && bus.snap_valid) begin
      snap_t e;
      if (sq.size() == 0) chk("snap_unexpected", 64'(bus.snap_valid), 0);
      else begin
        e = sq.pop_front();
        chk("snap_id", 64'(bus.snap_id), 64'(e.id));
        chk("snap_data", bus.snap_data, e.data);
        chk("gnt", 64'(bus.gnt), 64'(1) << e.id);
      end
    end
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0]  = '{CMD_LOAD,         64'hFFFF_FFFF_FFFF_FFFE, 0, 64'hFFFF_FFFF_FFFF_FFFE};
    tbl[1]  = '{CMD_LOAD,         64'hFFFF_FFFF_FFFF_FFFE, 1, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[2]  = '{CMD_LOAD,         64'hFFFF_FFFF_FFFF_FFFE, 2, 64'd0};
    tbl[3]  = '{CMD_LOAD,         64'd99,                  0, 64'd99};
    tbl[4]  = '{CMD_ADJUST,       -64'sd5,                 0, 64'd96};
    tbl[5]  = '{CMD_ADJUST,       64'd10,                  3, 64'd111};
    tbl[6]  = '{CMD_SET_INC_INT,  64'd3,                   4, 64'd125};
    tbl[7]  = '{CMD_SET_INC_INT,  64'd0,                   2, 64'd131};
    tbl[8]  = '{CMD_SET_INC_FRAC, 64'h80_0000,             8, 64'd135};
    tbl[9]  = '{CMD_SET_INC_FRAC, 64'd0,                   2, 64'd136};
    tbl[10] = '{CMD_SET_INC_INT,  64'd1,                   1, 64'd137};
    tbl[11] = '{CMD_LOAD,         64'd1000,                5, 64'd1005};
    tbl[12] = '{CMD_ADJUST,       64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd1006};
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = CMD_SET_INC_INT;
    bus.cmd_data  = '0;
    bus.req       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stamp", bus.stamp_counter, 0);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 0);
    chk("rst_snap_valid", 64'(bus.snap_valid), 0);
    chk("rst_gnt", 64'(bus.gnt), 0);
    chk("rst_snap_data", bus.snap_data, 0);
    chk("rst_snap_id", 64'(bus.snap_id), 0);
    @(negedge clk) rst = 1'b0;
    repeat (10) tick();
    chk("free_run_10", bus.stamp_counter, 10);
    chk("free_run_no_snap", 64'(bus.snap_valid), 0);
    st = 64'd10;
    run_req(4'b1111, 8);
    run_req(4'b1010, 4);
    run_req(4'b0100, 2);
    tick();
    tick();
    chk("arb_drain", 64'(sq.size()), 0);
    chk("stamp_after_arb", bus.stamp_counter, 26);
    for (int i = 0; i < 13; i++) begin
      cmd(tbl[i].op, tbl[i].data);
      repeat (tbl[i].n) tick();
      chk($sformatf("vec%0d_stamp", i), bus.stamp_counter, tbl[i].exp);
    end
    cmd(CMD_LOAD, 64'd49);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = CMD_LOAD;
    bus.cmd_data  = 64'd1000;
    tick();
    bus.cmd_valid = 1'b0;
    chk("coincide_pre_stamp", bus.stamp_counter, 50);
    bus.req = 4'b0001;
    sq.push_back('{2'd0, 64'd50});
    tick();
    chk("coincide_loaded", bus.stamp_counter, 1000);
    bus.req = 4'b0010;
    sq.push_back('{2'd1, 64'd1000});
    tick();
    bus.req = '0;
    tick();
    chk("coincide_drain", 64'(sq.size()), 0);
`ifdef STAMP_COUNTER_SCHED_PPS_EN
    begin
      int w = 0;
      cmd(CMD_LOAD, 64'd199);
      tick();
      pps = 1'b1;
      tick();
      while (!pps_valid && w < 6) begin
        tick();
        w++;
      end
      chk("pps_valid", 64'(pps_valid), 1);
      chk("pps_stamp_window", 64'(pps_stamp == 64'd202 || pps_stamp == 64'd203), 1);
      pps = 1'b0;
    end
`endif
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = CMD_LOAD;
    bus.cmd_data  = 64'd5555;
    tick();
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_stamp", bus.stamp_counter, 0);
    chk("abort_cmd_ready", 64'(bus.cmd_ready), 0);
    tick();
    tick();
    chk("abort_hold", bus.stamp_counter, 0);
    @(negedge clk) rst = 1'b0;
    tick();
    tick();
    chk("abort_no_load", bus.stamp_counter, 2);
    chk("abort_ready", 64'(bus.cmd_ready), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
